// File: rtl/seq_add_nibble.sv
`default_nettype none
// ============================================================================
// Module   : seq_add_nibble
// Brief    : Multi-cycle wide adder; feeds one 4-bit ripple-carry adder a
//            nibble per cycle, LSB first, with valid/ready on both sides.
// Revision : 1.0  initial release
// ============================================================================

module seq_add_nibble_rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic w_c1;
    logic w_c2;
    logic w_c3;

    assign s[0]  = a[0] ^ b[0] ^ c_in;
    assign w_c1  = (a[0] & b[0]) | (a[0] & c_in) | (b[0] & c_in);
    assign s[1]  = a[1] ^ b[1] ^ w_c1;
    assign w_c2  = (a[1] & b[1]) | (a[1] & w_c1) | (b[1] & w_c1);
    assign s[2]  = a[2] ^ b[2] ^ w_c2;
    assign w_c3  = (a[2] & b[2]) | (a[2] & w_c2) | (b[2] & w_c2);
    assign s[3]  = a[3] ^ b[3] ^ w_c3;
    assign c_out = (a[3] & b[3]) | (a[3] & w_c3) | (b[3] & w_c3);
endmodule

module seq_add_nibble #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 c_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out,
    output logic                 ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_sum;
    logic            r_c_out;
    logic            r_ovf;

    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [3:0]      w_s;
    logic            w_c;

    assign w_a_nib = r_a[{r_cnt, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_cnt, 2'b00} +: 4];

    seq_add_nibble_rca4 u_rca4 (
        .a     (w_a_nib),
        .b     (w_b_nib),
        .c_in  (r_carry),
        .s     (w_s),
        .c_out (w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_sum[{r_cnt, 2'b00} +: 4] <= w_s;
                    r_carry                    <= w_c;
                    // Last nibble: its sum bit 3 is the new result MSB.
                    if (r_cnt == C_LAST) begin
                        r_c_out <= w_c;
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_s[3] != r_a[W-1]);
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_seq_add_nibble.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_add_nibble
// Brief    : Directed self-checking bench for seq_add_nibble (NIBBLES = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_add_nibble;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    seq_add_nibble #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation with out_ready high; check latency, result, 1-cycle pulse.
    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = av; b = bv; c_in = ci; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(N));
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_c_out"}, 32'(c_out), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        step();
        chk({tag, "_pulse"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    logic         pc [3];
    logic [W-1:0] ps [3];
    logic         pco [3];
    logic         po [3];
    int           acc [3];

    initial begin
        int k;
        int r;
        int cyc;
        logic [W-1:0] held_sum;

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'({sum, c_out, ovf}), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        do_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        do_op("ovf_pos", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure: 0x8001 + 0x8002 = 0x0003, carry out, signed overflow.
        a = 16'h8001; b = 16'h8002; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (N) step();
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        held_sum = sum;
        chk("bp_sum", 32'({sum, c_out, ovf}), 32'({16'h0003, 1'b1, 1'b1}));
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid; a = a + 16'h1111; b = b ^ 16'hF0F0;
            step();
            chk("bp_hold", 32'({sum, c_out, ovf, out_valid, in_ready}),
                32'({held_sum, 1'b1, 1'b1, 1'b1, 1'b0}));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_release", 32'({out_valid, in_ready}), 32'b01);

        // Reset abort after 2 ADD edges.
        a = 16'h1234; b = 16'h4321; c_in = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("abort_partial", 32'(sum), 32'h0055);
        rst_n = 1'b0;
        #1;
        chk("abort_flags", 32'({out_valid, in_ready}), 32'b01);
        chk("abort_sum", 32'(sum), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("abort_no_valid", 32'(out_valid), 32'd0);
        do_op("post_abort", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        pa[0] = 16'h1111; pb[0] = 16'h2222; pc[0] = 1'b0; ps[0] = 16'h3333; pco[0] = 1'b0; po[0] = 1'b0;
        pa[1] = 16'hA5A5; pb[1] = 16'h5A5A; pc[1] = 1'b1; ps[1] = 16'h0000; pco[1] = 1'b1; po[1] = 1'b0;
        pa[2] = 16'h4000; pb[2] = 16'h4000; pc[2] = 1'b0; ps[2] = 16'h8000; pco[2] = 1'b0; po[2] = 1'b1;
        k = 0; r = 0; cyc = 0;
        out_ready = 1'b1;
        while (r < 3 && cyc < 60) begin
            if (in_ready && k < 3) begin
                a = pa[k]; b = pb[k]; c_in = pc[k]; in_valid = 1'b1;
                acc[k] = cyc + 1;
                k++;
            end else if (k >= 3) begin
                in_valid = 1'b0;
            end
            step();
            cyc++;
            if (out_valid) begin
                chk("b2b_result", 32'({sum, c_out, ovf}), 32'({ps[r], pco[r], po[r]}));
                r++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", 32'(r), 32'd3);
        chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'(N + 2));
        chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'(N + 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_add_nibble.md
# seq_add_nibble

Multi-cycle wide adder that slices two `4*NIBBLES`-bit operands into 4-bit nibbles and feeds them, least-significant first, into one instance of the team's 4-bit ripple-carry adder (`a[3:0]`, `b[3:0]`, `c_in` → `s[3:0]`, `c_out`). The block is the stage directly upstream and downstream of that adder: it supplies the adder's operands, registers the carry between nibbles, and collects the sum nibbles. It presents valid/ready handshakes on both sides so datapath controllers can issue wide additions at low area cost.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; W = 4*NIBBLES; legal range ≥ 1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operands and `c_in` are valid.
- `in_ready`  out  1  block accepts operands this cycle.
- `a`  in  W  addend A (unsigned or two's complement).
- `b`  in  W  addend B.
- `c_in`  in  1  carry into nibble 0.
- `out_valid`  out  1  `sum`, `c_out`, `ovf` hold a complete result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `sum`  out  W  A + B + c_in, modulo 2^W.
- `c_out`  out  1  carry out of bit W-1.
- `ovf`  out  1  signed overflow: (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]).

## Operation
- FSM states: IDLE, ADD, DONE. `in_ready` = (state == IDLE). `out_valid` = (state == DONE). Both are decoded from registered state only.
- IDLE: on an edge with `in_valid && in_ready`, latch `a`, `b`, and `c_in` into internal operand registers. Load the carry register with `c_in`. Set nibble counter `cnt` = 0. Go to ADD.
- ADD: the adder instance sees `a_q[4*cnt+3:4*cnt]`, `b_q[4*cnt+3:4*cnt]`, and the carry register. On each edge:
  - `sum[4*cnt+3:4*cnt]` ← adder `s`.
  - Carry register ← adder `c_out`.
  - `cnt` ← `cnt`+1.
- When `cnt` == NIBBLES-1, that edge also loads `c_out` from the adder carry, computes `ovf` from `a_q`, `b_q`, and the new sum MSB, and moves to DONE.
- DONE: `sum`, `c_out`, and `ovf` are held stable. On an edge with `out_ready` = 1, return to IDLE. `in_valid` is ignored in ADD and DONE.
- Input changes after the accept edge have no effect; operands are taken from `a_q`/`b_q` only.
- `cnt` width is clog2(NIBBLES), minimum 1 bit. No wrap occurs, because the FSM exits ADD at NIBBLES-1.
- NIBBLES = 1: exactly one ADD cycle, then DONE.
- `sum` is written nibble-by-nibble during ADD, so it shows partial values there. Its value is defined for the consumer only while `out_valid` = 1.

## Timing
- Reset, asynchronous on `rst_n` low:
  - state = IDLE, `cnt` = 0, carry register = 0.
  - `sum` = 0, `c_out` = 0, `ovf` = 0.
  - `out_valid` = 0, `in_ready` = 1 (`in_ready` is high while reset is asserted).
- Reset mid-ADD or mid-DONE aborts the operation. No `out_valid` pulse appears afterwards, and the next accepted operation is fully correct.
- Latency: `out_valid` rises after exactly NIBBLES rising edges following the accept edge. With NIBBLES = 4, accept at edge E0 gives `out_valid` high after E4.
- If `out_ready` is already 1 when DONE is entered, `out_valid` is high for exactly one cycle.
- Maximum throughput: one operation per NIBBLES+2 cycles:
  - accept edge, then NIBBLES ADD edges, then the output-handshake edge.
  - `in_ready` returns in the cycle after the output handshake.
- No combinational path from `in_valid` or `out_ready` to any output.

## Test plan
- NIBBLES = 4, `a` = 0x1234, `b` = 0x4321, `c_in` = 0, `out_ready` = 1 → `sum` = 0x5555, `c_out` = 0, `ovf` = 0; `out_valid` is high exactly 4 edges after accept, for 1 cycle.
- `a` = 0xFFFF, `b` = 0x0001, `c_in` = 0 → `sum` = 0x0000, `c_out` = 1, `ovf` = 0 (carry ripples through all 4 nibble cycles). Repeat with `a` = 0xFFFF, `b` = 0x0000, `c_in` = 1 → same result.
- `a` = 0x7FFF, `b` = 0x0000, `c_in` = 1 → `sum` = 0x8000, `c_out` = 0, `ovf` = 1. Also `a` = 0x8000, `b` = 0x8000 → `sum` = 0x0000, `c_out` = 1, `ovf` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE while toggling `in_valid`, `a`, and `b` → `sum`/`c_out`/`ovf` stay stable, `in_ready` = 0, no new operation starts. Then `out_ready` = 1 → IDLE next cycle.
- Reset abort: deassert `rst_n` after 2 ADD edges → immediately `out_valid` = 0, `in_ready` = 1, `sum` = 0. Release reset and add 0x00FF + 0x0F01 → `sum` = 0x1000, `c_out` = 0.
- Back-to-back: `in_valid` and `out_ready` held at 1 with 3 different operand pairs → accepts spaced exactly 6 edges apart, all three results correct and in order.
